paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/pong_pkg.sv | 62 ++++++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/paddle_ctrl.sv | 137 +++++++++++++
 tb/tb_paddle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared constants and types for the pong paddle logic.
//   SCREEN_H       : visible screen height in rows
//   PADDLE_H       : paddle height in rows
//   PADDLE_MAX_Y   : lowest legal top-edge row of the paddle
//   PADDLE_START_Y : top-edge row the paddle returns to on reset
//   Y_W            : width of a row coordinate
//   dir_t          : resolved movement request for one frame
// Helpers:
//   decode_dir     : turn the two accepted button levels into a dir_t
//   step_y         : move a row coordinate one step, clamped to the screen
// ---------------------------------------------------------------------------
package pong_pkg;

    localparam int SCREEN_H       = 480;
    localparam int PADDLE_H       = 64;
    localparam int PADDLE_MAX_Y   = SCREEN_H - PADDLE_H;
    localparam int PADDLE_START_Y = 208;
    localparam int Y_W            = 10;

    localparam logic [Y_W-1:0] PADDLE_MAX_Y_V   = Y_W'(PADDLE_MAX_Y);
    localparam logic [Y_W-1:0] PADDLE_START_Y_V = Y_W'(PADDLE_START_Y);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // Opposing requests cancel out, so "both" resolves to no movement.
    function automatic dir_t decode_dir(input logic up, input logic down);
        dir_t d;
        d = DIR_NONE;
        if (up && !down) begin
            d = DIR_UP;
        end else if (down && !up) begin
            d = DIR_DOWN;
        end
        return d;
    endfunction

    // The downward sum is carried one bit wider so a position near the
    // bottom plus a step cannot wrap before it is compared with the limit.
    function automatic logic [Y_W-1:0] step_y(
        input logic [Y_W-1:0] y,
        input dir_t           dir,
        input logic [Y_W-1:0] step
    );
        logic [Y_W:0]   sum;
        logic [Y_W-1:0] res;
        sum = {1'b0, y} + {1'b0, step};
        res = y;
        case (dir)
            DIR_UP:   res = (y < step) ? '0 : (y - step);
            DIR_DOWN: res = (sum > {1'b0, PADDLE_MAX_Y_V}) ? PADDLE_MAX_Y_V : sum[Y_W-1:0];
            default:  res = y;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one
// raw push-button.
//   clk     : system clock
//   rst     : asynchronous, active-low reset
//   i_btn   : raw asynchronous button level, active-high
//   o_level : accepted (debounced) button level
// The accepted level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES cycles in a row; a single cycle of agreement
// restarts the count. Raw edge to accepted level is 2 + DEBOUNCE_CYCLES.
// ---------------------------------------------------------------------------
module btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic             w_level_next;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_level_next = r_level;
        w_cnt_next   = '0;
        if (r_sync2 != r_level) begin
            if (r_cnt >= CNT_LAST) begin
                // This cycle completes the run of disagreement.
                w_level_next = r_sync2;
                w_cnt_next   = '0;
            end else if (r_cnt != CNT_SAT) begin
                w_cnt_next = r_cnt + CNT_ONE;
            end else begin
                w_cnt_next = r_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_level <= w_level_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/paddle_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_ctrl
// Moves the pong paddle up/down once per video frame from two debounced
// push-buttons.
//   clk       : system clock (single clock domain)
//   rst       : asynchronous, active-low reset
//   enable    : game-run qualifier; paddle holds while low
//   btnUp     : raw up button, active-high, asynchronous
//   btnDown   : raw down button, active-high, asynchronous
//   frameTick : one-cycle pulse per video frame
//   paddleY   : registered top-edge row of the paddle
//   moving    : one-cycle pulse after a tick that changed paddleY
//   atTop     : paddleY is at row 0
//   atBottom  : paddleY is at PADDLE_MAX_Y
// Optional feature macro: PADDLE_ACCEL_EN. When defined, the step grows by
// one per tick of continued same-direction movement, up to MAX_SPEED, and
// falls back to SPEED whenever the resolved direction changes (release,
// reversal or both pressed). Without it the step is the constant SPEED.
// ---------------------------------------------------------------------------
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SPEED           = 4,
    parameter int MAX_SPEED       = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           btnUp,
    input  logic           btnDown,
    input  logic           frameTick,
    output logic [Y_W-1:0] paddleY,
    output logic           moving,
    output logic           atTop,
    output logic           atBottom
);

    localparam logic [Y_W-1:0] SPEED_V = Y_W'(SPEED);

    // Reject parameter sets the step arithmetic cannot honour.
    if (SPEED < 1 || SPEED > MAX_SPEED || MAX_SPEED > PADDLE_MAX_Y || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("paddle_ctrl: illegal SPEED/MAX_SPEED/DEBOUNCE_CYCLES combination");
    end

    logic           w_up_level;
    logic           w_down_level;
    dir_t           w_dir;
    logic           w_move_en;
    logic [Y_W-1:0] w_step;
    logic [Y_W-1:0] w_y_cand;

    logic [Y_W-1:0] r_paddle_y;
    logic           r_moving;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btnUp),
        .o_level (w_up_level)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_down (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btnDown),
        .o_level (w_down_level)
    );

    assign w_dir     = decode_dir(w_up_level, w_down_level);
    assign w_move_en = frameTick & enable;

`ifdef PADDLE_ACCEL_EN
    localparam logic [Y_W-1:0] MAX_SPEED_V = Y_W'(MAX_SPEED);
    localparam logic [Y_W-1:0] SPEED_ONE   = Y_W'(1);

    // r_run_dir is the direction of the current acceleration run; it is
    // dropped to DIR_NONE in any cycle the resolved direction departs from
    // it, so a release/re-press between two ticks still restarts at SPEED.
    dir_t           r_run_dir;
    logic [Y_W-1:0] r_speed;
    dir_t           w_run_dir_next;
    logic [Y_W-1:0] w_speed_next;

    always_comb begin
        w_step         = (w_dir == r_run_dir) ? r_speed : SPEED_V;
        w_speed_next   = r_speed;
        w_run_dir_next = r_run_dir;
        if (w_move_en && (w_dir != DIR_NONE)) begin
            w_speed_next   = (w_step >= MAX_SPEED_V) ? MAX_SPEED_V : (w_step + SPEED_ONE);
            w_run_dir_next = w_dir;
        end else if (w_dir != r_run_dir) begin
            w_speed_next   = SPEED_V;
            w_run_dir_next = DIR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_speed   <= SPEED_V;
            r_run_dir <= DIR_NONE;
        end else begin
            r_speed   <= w_speed_next;
            r_run_dir <= w_run_dir_next;
        end
    end
`else
    assign w_step = SPEED_V;
`endif

    assign w_y_cand = step_y(r_paddle_y, w_dir, w_step);

    // moving reflects an actual change, so a clamp that is already at the
    // limit (or a cancelled/idle request) leaves it low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_paddle_y <= PADDLE_START_Y_V;
            r_moving   <= 1'b0;
        end else begin
            r_moving <= 1'b0;
            if (w_move_en) begin
                r_paddle_y <= w_y_cand;
                r_moving   <= (w_y_cand != r_paddle_y);
            end
        end
    end

    assign paddleY  = r_paddle_y;
    assign moving   = r_moving;
    assign atTop    = (r_paddle_y == '0);
    assign atBottom = (r_paddle_y == PADDLE_MAX_Y_V);

endmodule

// File: tb/tb_paddle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_paddle_ctrl
// Two paddle_ctrl instances (SPEED 4 and SPEED 6, same buttons) are driven
// with directed and random button/tick/enable patterns. A reference model
// derives the accepted button levels from the raw sample history and moves
// its own paddle positions with plain integer arithmetic; expected results
// are queued per frame tick and a separate monitor pops and compares them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_paddle_ctrl;

    localparam int DC      = 16;
    localparam int MAXS    = 12;
    localparam int MAX_Y   = 416;
    localparam int START_Y = 208;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       enable    = 1'b0;
    logic       btnUp     = 1'b0;
    logic       btnDown   = 1'b0;
    logic       frameTick = 1'b0;

    logic [9:0] y0, y1;
    logic       mv0, mv1, top0, top1, bot0, bot1;

    always #5 clk = ~clk;

    paddle_ctrl #(.DEBOUNCE_CYCLES(DC), .SPEED(4), .MAX_SPEED(MAXS)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .btnUp(btnUp), .btnDown(btnDown),
        .frameTick(frameTick), .paddleY(y0), .moving(mv0), .atTop(top0), .atBottom(bot0)
    );

    paddle_ctrl #(.DEBOUNCE_CYCLES(DC), .SPEED(6), .MAX_SPEED(MAXS)) u_dut6 (
        .clk(clk), .rst(rst), .enable(enable), .btnUp(btnUp), .btnDown(btnDown),
        .frameTick(frameTick), .paddleY(y1), .moving(mv1), .atTop(top1), .atBottom(bot1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int inst;
        int y;
        bit mv;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    int speeds[2] = '{4, 6};
    int m_y[2];
    int hist_up[$];
    int hist_dn[$];
    bit acc_up, acc_dn;
    int run_dir, run_len;

    // A level is accepted once the raw button showed it on DC consecutive
    // edges, those edges ending two edges ago (synchronizer delay).
    function automatic bit held_for_window(input int h[$], input int v);
        int n;
        n = h.size();
        if (n < DC + 2) return 1'b0;
        for (int j = n - 2 - DC; j <= n - 3; j++) begin
            if (h[j] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int dir_of(input bit up, input bit dn);
        if (up && !dn) return 1;
        if (dn && !up) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        hist_up.delete();
        hist_dn.delete();
        acc_up  = 1'b0;
        acc_dn  = 1'b0;
        m_y[0]  = START_Y;
        m_y[1]  = START_Y;
        run_dir = 0;
        run_len = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
            end else begin
                if (frameTick && enable) begin
                    int d;
                    d = dir_of(acc_up, acc_dn);
                    for (int i = 0; i < 2; i++) begin
                        int step, old;
                        exp_t e;
                        step = speeds[i];
`ifdef PADDLE_ACCEL_EN
                        step = (speeds[i] + run_len > MAXS) ? MAXS : speeds[i] + run_len;
`endif
                        old = m_y[i];
                        if (d == 1) m_y[i] = (old - step < 0) ? 0 : old - step;
                        if (d == 2) m_y[i] = (old + step > MAX_Y) ? MAX_Y : old + step;
                        e.inst = i;
                        e.y    = m_y[i];
                        e.mv   = (m_y[i] != old);
                        exp_q.push_back(e);
                    end
                    if (d != 0) run_len++;
                end
                hist_up.push_back(int'(btnUp));
                hist_dn.push_back(int'(btnDown));
                if (hist_up.size() > DC + 4) void'(hist_up.pop_front());
                if (hist_dn.size() > DC + 4) void'(hist_dn.pop_front());
                if (!acc_up && held_for_window(hist_up, 1)) acc_up = 1'b1;
                else if (acc_up && held_for_window(hist_up, 0)) acc_up = 1'b0;
                if (!acc_dn && held_for_window(hist_dn, 1)) acc_dn = 1'b1;
                else if (acc_dn && held_for_window(hist_dn, 0)) acc_dn = 1'b0;
                if (dir_of(acc_up, acc_dn) != run_dir) begin
                    run_dir = dir_of(acc_up, acc_dn);
                    run_len = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                if (mv0 !== 1'b0 || mv1 !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_moving t=%0t: moving=%b/%b, expected 0/0 (no tick)", $time, mv0, mv1);
                end
            end
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [9:0] ay;
                logic am, at, ab;
                bit et, eb;
                e  = exp_q.pop_front();
                ay = (e.inst == 0) ? y0 : y1;
                am = (e.inst == 0) ? mv0 : mv1;
                at = (e.inst == 0) ? top0 : top1;
                ab = (e.inst == 0) ? bot0 : bot1;
                et = (e.y == 0);
                eb = (e.y == MAX_Y);
                checks++;
                if (ay !== 10'(e.y) || am !== e.mv || at !== et || ab !== eb) begin
                    errors++;
                    $display("FAIL tick_inst%0d t=%0t: paddleY=%0d moving=%b atTop=%b atBottom=%b, expected paddleY=%0d moving=%b atTop=%b atBottom=%b",
                             e.inst, $time, ay, am, at, ab, e.y, e.mv, et, eb);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // tick_period > 0: periodic ticks; 0: random ticks.
    task automatic run(input bit up, input bit dn, input bit en, input int cycles, input int tick_period);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            btnUp   = up;
            btnDown = dn;
            enable  = en;
            if (tick_period > 0) frameTick = ((c % tick_period) == tick_period - 1);
            else                 frameTick = (($urandom % 5) == 0);
        end
    endtask

    task automatic reset_mid_run();
        @(posedge clk);
        #1;
        frameTick = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (y0 !== 10'd208 || y1 !== 10'd208 || mv0 !== 1'b0 || mv1 !== 1'b0 ||
            top0 !== 1'b0 || top1 !== 1'b0 || bot0 !== 1'b0 || bot1 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset t=%0t: paddleY=%0d/%0d moving=%b/%b atTop=%b/%b atBottom=%b/%b, expected 208/208 0/0 0/0 0/0",
                     $time, y0, y1, mv0, mv1, top0, top1, bot0, bot1);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (y0 !== 10'd208 || y1 !== 10'd208 || mv0 !== 1'b0 || top0 !== 1'b0 || bot0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: paddleY=%0d/%0d moving=%b atTop=%b atBottom=%b, expected 208/208 0 0 0",
                     y0, y1, mv0, top0, bot0);
        end
        rst = 1'b1;

        run(1, 0, 1, 10, 100);     // glitch shorter than the debounce window
        run(0, 0, 1, 30, 8);       // ticks: must not move
        run(1, 0, 1, 30, 100);     // hold up long enough to be accepted
        run(1, 0, 1, 12, 4);       // three ticks moving up
        run(1, 0, 1, 300, 4);      // drive into the top and clamp there
        run(1, 1, 1, 60, 4);       // both pressed: hold
        run(0, 1, 1, 600, 4);      // drive into the bottom and clamp there
        run(0, 1, 0, 60, 4);       // enable low: hold
        run(1, 0, 1, 40, 4);       // up again, then reset mid-move
        reset_mid_run();
        run(1, 0, 1, 12, 4);       // not yet re-debounced after reset
        run(1, 0, 1, 40, 4);
        run(0, 0, 1, 20, 4);
        run(0, 1, 1, 40, 4);       // release / re-press restarts the run

        for (int s = 0; s < 90; s++) begin
            run(1'($urandom % 2), 1'($urandom % 2), (($urandom % 8) != 0),
                $urandom_range(1, 60), (($urandom % 3) == 0) ? 0 : int'($urandom_range(2, 9)));
            if (s == 45) reset_mid_run();
        end

        @(posedge clk);
        #1;
        frameTick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
